// File: rtl/fft_stream_io_if.sv
// Sample stream interface for fft_stream_io.
//   iIN_VALID / iIN_DATA / oIN_READY : time-domain input samples (real, signed D_BIT)
//   oOUT_VALID / iOUT_READY          : result stream handshake
//   oOUT_RE / oOUT_IM                : result sample, D_BIT+1 bits each
//   oOUT_IDX / oOUT_LAST             : output index k and end-of-frame flag
// slave  = the streaming block (consumes input, produces output)
// master = the environment (produces input, consumes output)
interface fft_stream_io_if #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 9
);
  logic                    iIN_VALID;
  logic signed [D_BIT-1:0] iIN_DATA;
  logic                    oIN_READY;
  logic                    oOUT_VALID;
  logic                    iOUT_READY;
  logic signed [D_BIT:0]   oOUT_RE;
  logic signed [D_BIT:0]   oOUT_IM;
  logic [A_BIT+1:0]        oOUT_IDX;
  logic                    oOUT_LAST;

  modport slave (
    input  iIN_VALID, iIN_DATA, iOUT_READY,
    output oIN_READY, oOUT_VALID, oOUT_RE, oOUT_IM, oOUT_IDX, oOUT_LAST
  );

  modport master (
    output iIN_VALID, iIN_DATA, iOUT_READY,
    input  oIN_READY, oOUT_VALID, oOUT_RE, oOUT_IM, oOUT_IDX, oOUT_LAST
  );
endinterface

// File: rtl/fft_stream_io.sv
// Streaming load/unload front-end for the radix-4 FFT datapath.
// Loads N = 4*2^A_BIT real samples interleaved across the four banks of RAM A,
// kicks the engine, waits for completion, then streams the results back in
// natural or bit-reversed order through a 2-entry output buffer.
// Ports:
//   iCLK, iRESET (async, active-low)
//   iSTART  : frame start pulse (IDLE only)    iABORT : synchronous abort to IDLE
//   strm    : input/output sample streams (fft_stream_io_if.slave)
//   oENG_START / iENG_RDY : engine start pulse / completion
//   oSOURCE_CONT          : 1 while this block owns the RAM A ports
//   oRAM_WE / oRAM_ADDR_WR / oRAM_DATA : registered bank write port
//   oRAM_ADDR_RD / iRAM_RE / iRAM_IM   : bank read port, 1-cycle read latency
//   oBUSY, oDONE          : frame in progress / end-of-frame pulse
module fft_stream_io #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 9,
  parameter int BITREV = 1
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iSTART,
  input  logic                   iABORT,
  fft_stream_io_if.slave         strm,
  output logic                   oENG_START,
  input  logic                   iENG_RDY,
  output logic                   oSOURCE_CONT,
  output logic [3:0]             oRAM_WE,
  output logic [A_BIT-1:0]       oRAM_ADDR_WR,
  output logic signed [D_BIT:0]  oRAM_DATA,
  output logic [A_BIT-1:0]       oRAM_ADDR_RD,
  input  logic [4*(D_BIT+1)-1:0] iRAM_RE,
  input  logic [4*(D_BIT+1)-1:0] iRAM_IM,
  output logic                   oBUSY,
  output logic                   oDONE
);

  localparam int W  = D_BIT + 1;
  localparam int IW = A_BIT + 2;
  localparam int CW = A_BIT + 3;
  localparam int N  = 1 << IW;
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [IW-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD} state_t;

  function automatic logic signed [W-1:0] sign_ext(input logic signed [D_BIT-1:0] x);
    return {x[D_BIT-1], x};
  endfunction

  function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] x);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = x[IW-1-i];
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         in_cnt_q, in_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  eng_start_q, eng_start_d;
  logic                  done_q, done_d;

  logic [3:0]            wr_we_p0, wr_we_p1;
  logic [A_BIT-1:0]      wr_addr_p0, wr_addr_p1;
  logic signed [W-1:0]   wr_data_p0, wr_data_p1;

  logic                  rd_vld_p0, rd_vld_p1;
  logic [1:0]            rd_bank_p0, rd_bank_p1;
  logic [IW-1:0]         rd_idx_p0, rd_idx_p1;
  logic [IW-1:0]         rd_j;

  logic [1:0]            fcnt_p2, fcnt_d;
  logic [1:0]            f_occ;
  logic signed [W-1:0]   f0_re_p2, f0_im_p2, f1_re_p2, f1_im_p2;
  logic [IW-1:0]         f0_idx_p2, f1_idx_p2;

  logic signed [W-1:0]   re_bank [4];
  logic signed [W-1:0]   im_bank [4];
  logic signed [W-1:0]   push_re, push_im;

  logic                  in_ready, in_hs;
  logic                  out_vld, out_hs, out_last;
  logic                  rd_issue;

  assign in_ready = (state_q == S_LOAD) && (in_cnt_q != N_CNT);
  assign in_hs    = strm.iIN_VALID && in_ready;
  assign out_vld  = (fcnt_p2 != 2'd0);
  assign out_hs   = out_vld && strm.iOUT_READY;
  assign out_last = out_vld && (f0_idx_p2 == LAST_IDX);

  assign rd_j  = (BITREV != 0) ? bit_rev(rd_cnt_q[IW-1:0]) : rd_cnt_q[IW-1:0];
  // Buffer occupancy after this cycle's pop, counting the read in flight.
  assign f_occ = fcnt_p2 + {1'b0, rd_vld_p1} - {1'b0, out_hs};
  assign rd_issue = (state_q == S_UNLOAD) && (rd_cnt_q != N_CNT) && (f_occ < 2'd2);

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      re_bank[b] = iRAM_RE[b*W +: W];
      im_bank[b] = iRAM_IM[b*W +: W];
    end
    push_re = re_bank[rd_bank_p1];
    push_im = im_bank[rd_bank_p1];
  end

  // Stage p0: control decode, write request and read issue
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    eng_start_d = 1'b0;
    done_d      = 1'b0;
    wr_we_p0    = 4'b0000;
    wr_addr_p0  = in_cnt_q[IW-1:2];
    wr_data_p0  = sign_ext(strm.iIN_DATA);
    rd_vld_p0   = 1'b0;
    rd_bank_p0  = rd_j[1:0];
    rd_idx_p0   = rd_cnt_q[IW-1:0];
    fcnt_d      = fcnt_p2 + {1'b0, rd_vld_p1} - {1'b0, out_hs};

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d  = S_LOAD;
          in_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          wr_we_p0 = 4'b0001 << in_cnt_q[1:0];
          in_cnt_d = in_cnt_q + CW'(1);
        end else if (in_cnt_q == N_CNT) begin
          // Final write is on the RAM port this cycle; hand over next cycle.
          state_d     = S_RUN;
          eng_start_d = 1'b1;
        end
      end
      S_RUN: begin
        if (iENG_RDY) begin
          state_d  = S_UNLOAD;
          rd_cnt_d = '0;
        end
      end
      S_UNLOAD: begin
        if (rd_issue) begin
          rd_vld_p0 = 1'b1;
          rd_cnt_d  = rd_cnt_q + CW'(1);
        end
        if (out_hs && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (iABORT) begin
      state_d     = S_IDLE;
      in_cnt_d    = '0;
      rd_cnt_d    = '0;
      eng_start_d = 1'b0;
      done_d      = 1'b0;
      wr_we_p0    = 4'b0000;
      rd_vld_p0   = 1'b0;
      fcnt_d      = 2'd0;
    end
  end

  // Stage p1: registered RAM write / read in flight; stage p2: output buffer
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      wr_we_p1    <= 4'b0000;
      rd_vld_p1   <= 1'b0;
      fcnt_p2     <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      eng_start_q <= eng_start_d;
      done_q      <= done_d;
      wr_we_p1    <= wr_we_p0;
      rd_vld_p1   <= rd_vld_p0;
      fcnt_p2     <= fcnt_d;
    end
  end

  always_ff @(posedge iCLK) begin
    wr_addr_p1 <= wr_addr_p0;
    wr_data_p1 <= wr_data_p0;
    rd_bank_p1 <= rd_bank_p0;
    rd_idx_p1  <= rd_idx_p0;
    // Entry 0 is the head presented on the output; entry 1 only fills under stall.
    if (out_hs) begin
      if (fcnt_p2 == 2'd2) begin
        f0_re_p2  <= f1_re_p2;
        f0_im_p2  <= f1_im_p2;
        f0_idx_p2 <= f1_idx_p2;
        if (rd_vld_p1) begin
          f1_re_p2  <= push_re;
          f1_im_p2  <= push_im;
          f1_idx_p2 <= rd_idx_p1;
        end
      end else if (rd_vld_p1) begin
        f0_re_p2  <= push_re;
        f0_im_p2  <= push_im;
        f0_idx_p2 <= rd_idx_p1;
      end
    end else if (rd_vld_p1) begin
      if (fcnt_p2 == 2'd0) begin
        f0_re_p2  <= push_re;
        f0_im_p2  <= push_im;
        f0_idx_p2 <= rd_idx_p1;
      end else begin
        f1_re_p2  <= push_re;
        f1_im_p2  <= push_im;
        f1_idx_p2 <= rd_idx_p1;
      end
    end
  end

  // Data outputs are qualified so idle cycles present zeros.
  assign strm.oIN_READY  = in_ready;
  assign strm.oOUT_VALID = out_vld;
  assign strm.oOUT_RE    = out_vld ? f0_re_p2  : '0;
  assign strm.oOUT_IM    = out_vld ? f0_im_p2  : '0;
  assign strm.oOUT_IDX   = out_vld ? f0_idx_p2 : '0;
  assign strm.oOUT_LAST  = out_last;

  assign oRAM_WE      = wr_we_p1;
  assign oRAM_ADDR_WR = (|wr_we_p1) ? wr_addr_p1 : '0;
  assign oRAM_DATA    = (|wr_we_p1) ? wr_data_p1 : '0;
  assign oRAM_ADDR_RD = rd_j[IW-1:2];
  assign oENG_START   = eng_start_q;
  assign oSOURCE_CONT = (state_q != S_RUN);
  assign oBUSY        = (state_q != S_IDLE);
  assign oDONE        = done_q;

endmodule

// File: tb/tb_fft_stream_io.sv
module tb_fft_stream_io;
  localparam int D_BIT = 16;
  localparam int A_BIT = 2;
  localparam int W     = D_BIT + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b1;
  logic               start, abort, eng_rdy;
  logic               eng_start, source_cont, busy, done;
  logic [3:0]         ram_we;
  logic [A_BIT-1:0]   ram_addr_wr, ram_addr_rd;
  logic signed [W-1:0] ram_data;
  logic [4*W-1:0]     ram_re, ram_im;

  int checks = 0;
  int errors = 0;

  int exp_br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_stream_io_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) sif ();

  fft_stream_io #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BITREV(1)) dut (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iABORT(abort),
    .strm(sif),
    .oENG_START(eng_start), .iENG_RDY(eng_rdy), .oSOURCE_CONT(source_cont),
    .oRAM_WE(ram_we), .oRAM_ADDR_WR(ram_addr_wr), .oRAM_DATA(ram_data),
    .oRAM_ADDR_RD(ram_addr_rd), .iRAM_RE(ram_re), .iRAM_IM(ram_im),
    .oBUSY(busy), .oDONE(done)
  );

  // Bank RAM model: registered read; imaginary part = real + 1000.
  logic [W-1:0] mem [4][4];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[b][ram_addr_wr] <= ram_data;
      ram_re[b*W +: W] <= mem[b][ram_addr_rd];
      ram_im[b*W +: W] <= mem[b][ram_addr_rd] + 17'd1000;
    end
  end

  task automatic load_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sif.iIN_VALID = 1'b1; sif.iIN_DATA = 16'(i);
      @(negedge clk);
    end
    sif.iIN_VALID = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_engine();
    eng_rdy = 1'b1;
    @(negedge clk);
    eng_rdy = 1'b0;
  endtask

  task automatic unload_frame(input bit rand_ready, input bit strict_first, input string tag);
    int k = 0;
    int cyc = 0;
    bit started = strict_first;
    bit r;
    while (k < 16 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (!rand_ready && started) begin
        checks++; if (sif.oOUT_VALID !== 1'b1) begin errors++; $display("FAIL %s_valid_gap k=%0d: got %0b expected 1", tag, k, sif.oOUT_VALID); end
      end
      if (sif.oOUT_VALID) begin
        started = 1'b1;
        checks++; if (sif.oOUT_RE !== 17'(exp_br[k])) begin errors++; $display("FAIL %s_re k=%0d: got %0d expected %0d", tag, k, sif.oOUT_RE, exp_br[k]); end
        checks++; if (sif.oOUT_IM !== 17'(exp_br[k] + 1000)) begin errors++; $display("FAIL %s_im k=%0d: got %0d expected %0d", tag, k, sif.oOUT_IM, exp_br[k] + 1000); end
        checks++; if (sif.oOUT_IDX !== 4'(k)) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", tag, sif.oOUT_IDX, k); end
        checks++; if (sif.oOUT_LAST !== (k == 15)) begin errors++; $display("FAIL %s_last k=%0d: got %0b expected %0b", tag, k, sif.oOUT_LAST, (k == 15)); end
        r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        sif.iOUT_READY = r;
        if (r) k++;
      end else begin
        sif.iOUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    checks++; if (k != 16) begin errors++; $display("FAIL %s_timeout: delivered %0d expected 16", tag, k); end
    @(negedge clk);
    sif.iOUT_READY = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done_pulse: got %0b expected 1", tag, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %0b expected 0", tag, busy); end
    checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL %s_valid_end: got %0b expected 0", tag, sif.oOUT_VALID); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %0b expected 0", tag, done); end
  endtask

  task automatic test_reset();
    start = 0; abort = 0; eng_rdy = 0;
    sif.iIN_VALID = 0; sif.iIN_DATA = '0; sif.iOUT_READY = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sif.oIN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b expected 0", sif.oIN_READY); end
    checks++; if (source_cont !== 1'b1) begin errors++; $display("FAIL rst_source_cont: got %0b expected 1", source_cont); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL rst_we: got %h expected 0", ram_we); end
    checks++; if (ram_addr_wr !== 2'd0) begin errors++; $display("FAIL rst_addr_wr: got %0d expected 0", ram_addr_wr); end
    checks++; if (ram_data !== 17'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", ram_data); end
    checks++; if (ram_addr_rd !== 2'd0) begin errors++; $display("FAIL rst_addr_rd: got %0d expected 0", ram_addr_rd); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL rst_eng_start: got %0b expected 0", eng_start); end
    checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", sif.oOUT_VALID); end
    checks++; if (sif.oOUT_IDX !== 4'd0) begin errors++; $display("FAIL rst_out_idx: got %0d expected 0", sif.oOUT_IDX); end
    checks++; if (sif.oOUT_LAST !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b expected 0", sif.oOUT_LAST); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_ignore();
    eng_rdy = 1'b1; sif.iIN_VALID = 1'b1; sif.iIN_DATA = 16'h0042;
    @(negedge clk);
    eng_rdy = 1'b0; sif.iIN_VALID = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_eng_rdy_busy: got %0b expected 0", busy); end
    checks++; if (source_cont !== 1'b1) begin errors++; $display("FAIL idle_source_cont: got %0b expected 1", source_cont); end
    checks++; if (sif.oIN_READY !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b expected 0", sif.oIN_READY); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL idle_we: got %h expected 0", ram_we); end
  endtask

  task automatic test_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (sif.oIN_READY !== 1'b1) begin errors++; $display("FAIL load_ready_first: got %0b expected 1", sif.oIN_READY); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %0b expected 1", busy); end
    for (int i = 0; i < 16; i++) begin
      sif.iIN_VALID = 1'b1; sif.iIN_DATA = 16'(i);
      @(negedge clk);
      checks++; if (ram_we !== 4'(1 << (i % 4))) begin errors++; $display("FAIL load_we i=%0d: got %h expected %h", i, ram_we, 4'(1 << (i % 4))); end
      checks++; if (ram_addr_wr !== 2'(i / 4)) begin errors++; $display("FAIL load_addr i=%0d: got %0d expected %0d", i, ram_addr_wr, i / 4); end
      checks++; if (ram_data !== 17'(i)) begin errors++; $display("FAIL load_data i=%0d: got %h expected %h", i, ram_data, 17'(i)); end
      checks++; if (sif.oIN_READY !== (i != 15)) begin errors++; $display("FAIL load_ready i=%0d: got %0b expected %0b", i, sif.oIN_READY, (i != 15)); end
      checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL load_early_start i=%0d: got %0b expected 0", i, eng_start); end
    end
    sif.iIN_VALID = 1'b0;
    @(negedge clk);
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL eng_start_pulse: got %0b expected 1", eng_start); end
    checks++; if (source_cont !== 1'b0) begin errors++; $display("FAIL run_source_cont: got %0b expected 0", source_cont); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL run_we: got %h expected 0", ram_we); end
    @(negedge clk);
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL eng_start_width: got %0b expected 0", eng_start); end
  endtask

  task automatic test_run_wait();
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++; if (source_cont !== 1'b0) begin errors++; $display("FAIL run_wait_source c=%0d: got %0b expected 0", c, source_cont); end
      checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL run_wait_valid c=%0d: got %0b expected 0", c, sif.oOUT_VALID); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_wait_busy c=%0d: got %0b expected 1", c, busy); end
    end
    run_engine();
    checks++; if (source_cont !== 1'b1) begin errors++; $display("FAIL unload_source_cont: got %0b expected 1", source_cont); end
    checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL unload_entry_valid: got %0b expected 0", sif.oOUT_VALID); end
    checks++; if (ram_addr_rd !== 2'd0) begin errors++; $display("FAIL unload_addr_k0: got %0d expected 0", ram_addr_rd); end
  endtask

  task automatic test_unload_bitrev();
    sif.iOUT_READY = 1'b1;
    @(negedge clk);
    checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL unload_valid_e1: got %0b expected 0", sif.oOUT_VALID); end
    checks++; if (ram_addr_rd !== 2'd2) begin errors++; $display("FAIL unload_addr_k1: got %0d expected 2", ram_addr_rd); end
    unload_frame(1'b0, 1'b1, "bitrev");
  endtask

  task automatic test_abort_load();
    logic [15:0] ab_in  [5];
    logic [16:0] ab_exp [5];
    ab_in  = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h1234};
    ab_exp = '{17'h18000, 17'h07FFF, 17'h00001, 17'h1FFFF, 17'h01234};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.iIN_VALID = 1'b1; sif.iIN_DATA = ab_in[i];
      @(negedge clk);
      checks++; if (ram_we !== 4'(1 << (i % 4))) begin errors++; $display("FAIL abort_we i=%0d: got %h expected %h", i, ram_we, 4'(1 << (i % 4))); end
      checks++; if (ram_data !== ab_exp[i]) begin errors++; $display("FAIL sext_data i=%0d: got %h expected %h", i, ram_data, ab_exp[i]); end
    end
    sif.iIN_DATA = 16'h5555; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; sif.iIN_VALID = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (sif.oIN_READY !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %0b expected 0", sif.oIN_READY); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL abort_we_after: got %h expected 0", ram_we); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL abort_eng_start: got %0b expected 0", eng_start); end
    checks++; if (source_cont !== 1'b1) begin errors++; $display("FAIL abort_source_cont: got %0b expected 1", source_cont); end
    @(negedge clk);
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL abort_we_later: got %h expected 0", ram_we); end
  endtask

  task automatic test_backpressure();
    load_frame();
    run_engine();
    unload_frame(1'b1, 1'b0, "bp");
  endtask

  task automatic test_reset_unload();
    load_frame();
    run_engine();
    sif.iOUT_READY = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (sif.oOUT_VALID !== 1'b1) begin errors++; $display("FAIL mid_unload_valid: got %0b expected 1", sif.oOUT_VALID); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %0b expected 0", sif.oOUT_VALID); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %0b expected 0", busy); end
    checks++; if (sif.oIN_READY !== 1'b0) begin errors++; $display("FAIL async_rst_in_ready: got %0b expected 0", sif.oIN_READY); end
    checks++; if (source_cont !== 1'b1) begin errors++; $display("FAIL async_rst_source: got %0b expected 1", source_cont); end
    checks++; if (sif.oOUT_IDX !== 4'd0) begin errors++; $display("FAIL async_rst_idx: got %0d expected 0", sif.oOUT_IDX); end
    @(negedge clk);
    rst_n = 1'b1; sif.iOUT_READY = 1'b0;
    @(negedge clk);
    checks++; if (sif.oOUT_VALID !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %0b expected 0", sif.oOUT_VALID); end
  endtask

  task automatic test_back_to_back();
    load_frame();
    run_engine();
    unload_frame(1'b0, 1'b0, "fresh");
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_load();
    test_run_wait();
    test_unload_bitrev();
    test_abort_load();
    test_backpressure();
    test_reset_unload();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
